// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel stopwatch controller: FSM encoding
// and the input-event slots, listed from highest to lowest priority.
package timer_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [ST_W-1:0] ST_RUN   = 2'b01;
    localparam logic [ST_W-1:0] ST_PAUSE = 2'b10;

    // Only the highest-priority edge present in a cycle acts: clr > stop > start > inc.
    localparam int EV_N     = 4;
    localparam int EV_CLR   = 3;
    localparam int EV_STOP  = 2;
    localparam int EV_START = 1;
    localparam int EV_INC   = 0;

endpackage

// File: rtl/timer_ctrl_mc_if.sv
// Button/status bundle between the debounced front panel and the display path.
interface timer_ctrl_mc_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16
);
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       stop;
    logic [N_CH-1:0]       inc;
    logic [N_CH-1:0]       clr;
    logic [N_CH-1:0]       cen;
    logic [N_CH-1:0]       running;
    logic [N_CH-1:0]       wrap;
    logic [N_CH*CNT_W-1:0] count;

    modport master (
        output start, stop, inc, clr,
        input  cen, running, wrap, count
    );

    modport slave (
        input  start, stop, inc, clr,
        output cen, running, wrap, count
    );
endinterface

// File: rtl/timer_chan.sv
// One stopwatch channel: input sync/edge detect, run/pause/idle FSM,
// inc auto-repeat and the wrapping count register.
module timer_chan
    import timer_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int CNT_MAX    = 9999,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic             o_cen,
    output logic             o_running,
    output logic             o_wrap,
    output logic [CNT_W-1:0] o_count
);

    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX);
    localparam logic [RPT_W-1:0] RPT_DLY_V = RPT_W'(REPEAT_DLY);
    localparam logic [RPT_W-1:0] RPT_PER_V = RPT_W'(REPEAT_PER);

    logic [EV_N-1:0]  r_in_q;
    logic [EV_N-1:0]  r_in_qq;
    logic [EV_N-1:0]  r_edge;
    logic             r_inc_lvl;
    logic [ST_W-1:0]  r_state;
    logic [RPT_W-1:0] r_rpt;
    logic             r_rpt_fast;
    logic             r_rpt_act;
    logic             r_cen;
    logic             r_running;
    logic             r_wrap;
    logic [CNT_W-1:0] r_count;

    logic             w_sel_clr;
    logic             w_sel_stop;
    logic             w_sel_start;
    logic             w_sel_inc;
    logic [ST_W-1:0]  w_next;
    logic             w_step_man;
    logic [RPT_W-1:0] w_rpt_tgt;
    logic [RPT_W-1:0] w_rpt_inc;
    logic             w_rpt_keep;
    logic             w_auto;

    // Edges are registered so the inc level is delayed to line up with them.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_in_q    <= '0;
            r_in_qq   <= '0;
            r_edge    <= '0;
            r_inc_lvl <= 1'b0;
        end else begin
            r_in_q    <= {i_clr, i_stop, i_start, i_inc};
            r_in_qq   <= r_in_q;
            r_edge    <= r_in_q & ~r_in_qq;
            r_inc_lvl <= r_in_q[EV_INC];
        end
    end

    assign w_sel_clr   = r_edge[EV_CLR];
    assign w_sel_stop  = r_edge[EV_STOP]  & ~r_edge[EV_CLR];
    assign w_sel_start = r_edge[EV_START] & ~(|r_edge[EV_CLR:EV_STOP]);
    assign w_sel_inc   = r_edge[EV_INC]   & ~(|r_edge[EV_CLR:EV_START]);

    always_comb begin
        w_next     = r_state;
        w_step_man = 1'b0;
        if (w_sel_clr) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_start) begin
                        w_next = ST_RUN;
                    end else if (w_sel_inc) begin
                        w_next     = ST_PAUSE;
                        w_step_man = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_sel_stop) begin
                        w_next = ST_PAUSE;
                    end else begin
                        w_next = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (w_sel_start) begin
                        w_next = ST_RUN;
                    end else if (w_sel_inc) begin
                        w_next     = ST_PAUSE;
                        w_step_man = 1'b1;
                    end else begin
                        w_next = ST_PAUSE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // The repeat counter only survives while parked in PAUSE with inc still held.
    always_comb begin
        w_rpt_tgt  = r_rpt_fast ? RPT_PER_V : RPT_DLY_V;
        w_rpt_inc  = r_rpt + RPT_W'(1);
        w_rpt_keep = (r_state == ST_PAUSE) && (w_next == ST_PAUSE) && r_inc_lvl && r_rpt_act;
        w_auto     = w_rpt_keep && !w_step_man && (w_rpt_inc == w_rpt_tgt);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rpt      <= '0;
            r_rpt_fast <= 1'b0;
            r_rpt_act  <= 1'b0;
        end else if (w_step_man) begin
            r_rpt      <= '0;
            r_rpt_fast <= 1'b0;
            r_rpt_act  <= 1'b1;
        end else if (!w_rpt_keep) begin
            r_rpt      <= '0;
            r_rpt_fast <= 1'b0;
            r_rpt_act  <= 1'b0;
        end else if (w_auto) begin
            r_rpt      <= '0;
            r_rpt_fast <= 1'b1;
            r_rpt_act  <= 1'b1;
        end else begin
            r_rpt      <= w_rpt_inc;
            r_rpt_fast <= r_rpt_fast;
            r_rpt_act  <= r_rpt_act;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_cen     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_running <= (w_next == ST_RUN);
            r_cen     <= (w_next == ST_RUN) | w_step_man | w_auto;
        end
    end

    // Count follows cen one edge later; a clear wins over a pending advance.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (w_sel_clr) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (r_cen) begin
            if (r_count == CNT_LAST) begin
                r_count <= '0;
                r_wrap  <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
                r_wrap  <= 1'b0;
            end
        end else begin
            r_count <= r_count;
            r_wrap  <= 1'b0;
        end
    end

    assign o_cen     = r_cen;
    assign o_running = r_running;
    assign o_wrap    = r_wrap;
    assign o_count   = r_count;

endmodule

// File: rtl/timer_ctrl_mc.sv
// Multi-channel stopwatch controller: N_CH independent timer_chan instances
// and the packing of their outputs onto the shared bus.
module timer_ctrl_mc #(
    parameter int N_CH       = 2,
    parameter int CNT_W      = 16,
    parameter int CNT_MAX    = 9999,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100
) (
    input  logic           msclk,
    input  logic           reset_n,
    timer_ctrl_mc_if.slave bus
);

    logic [N_CH-1:0]       w_cen;
    logic [N_CH-1:0]       w_running;
    logic [N_CH-1:0]       w_wrap;
    logic [N_CH*CNT_W-1:0] w_count;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        timer_chan #(
            .CNT_W      (CNT_W),
            .CNT_MAX    (CNT_MAX),
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
        ) u_chan (
            .i_clk     (msclk),
            .i_rst_n   (reset_n),
            .i_start   (bus.start[gi]),
            .i_stop    (bus.stop[gi]),
            .i_inc     (bus.inc[gi]),
            .i_clr     (bus.clr[gi]),
            .o_cen     (w_cen[gi]),
            .o_running (w_running[gi]),
            .o_wrap    (w_wrap[gi]),
            .o_count   (w_count[gi*CNT_W +: CNT_W])
        );
    end

    assign bus.cen     = w_cen;
    assign bus.running = w_running;
    assign bus.wrap    = w_wrap;
    assign bus.count   = w_count;

endmodule
